idu_decode_stage: RTL and testbench

Registered, handshaked RV32/RV64 base-integer decode stage for the npc IDU. Classifies the opcode, extracts register fields, and builds the sign-extended immediate (XLEN-wide) and shift amount. Results are held in a two-entry skid buffer between IFU and EXU so backpressure never forms a combinational ready path. Also supports pipeline flush, an illegal-instruction flag, and a saturating retired-decode counter.

---
 rtl/idu_decode_stage.sv | 167 ++++++++++++++++
 tb/tb_idu_decode_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_decode_stage.sv
// RV32/RV64 decode stage: one-cycle registered decode into a two-entry skid buffer.
// Backpressure: in_ready is a registered function of occupancy only, so out_ready/flush never reach it combinationally.
module idu_decode_stage #(
  parameter int XLEN        = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            inst,
  input  logic [XLEN-1:0]        pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [3:0]             op_class,
  output logic [2:0]             inst_type,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [XLEN-1:0]        imm,
  output logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   illegal,
  output logic [CNT_WIDTH-1:0]   decode_cnt
);

  localparam logic [3:0] C_INV = 4'd0, C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3,
                         C_JALR = 4'd4, C_BRANCH = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7,
                         C_OPIMM = 4'd8, C_OP = 4'd9, C_SYSTEM = 4'd10,
                         C_OPIMM32 = 4'd11, C_OP32 = 4'd12;
  localparam logic [2:0] T_N = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3,
                         T_B = 3'd4, T_U = 3'd5, T_J = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [3:0]             op_class;
    logic [2:0]             inst_type;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [XLEN-1:0]        imm;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   illegal;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, out_valid_q;
  entry_t               head_q, skid_q, dec;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [3:0]           cls;
  logic [2:0]           typ;
  logic signed [31:0]   imm32;
  logic                 in_fire, out_fire;

  always_comb begin
    cls = C_INV;
    typ = T_N;
    case (inst[6:0])
      7'b0110111: begin cls = C_LUI;    typ = T_U; end
      7'b0010111: begin cls = C_AUIPC;  typ = T_U; end
      7'b1101111: begin cls = C_JAL;    typ = T_J; end
      7'b1100111: begin cls = C_JALR;   typ = T_I; end
      7'b1100011: begin cls = C_BRANCH; typ = T_B; end
      7'b0000011: begin cls = C_LOAD;   typ = T_I; end
      7'b0100011: begin cls = C_STORE;  typ = T_S; end
      7'b0010011: begin cls = C_OPIMM;  typ = T_I; end
      7'b0110011: begin cls = C_OP;     typ = T_R; end
      7'b1110011: begin cls = C_SYSTEM; typ = T_I; end
      7'b0011011: if (XLEN == 64) begin cls = C_OPIMM32; typ = T_I; end
      7'b0111011: if (XLEN == 64) begin cls = C_OP32;    typ = T_R; end
      default: begin cls = C_INV; typ = T_N; end
    endcase
  end

  // Built as a signed 32-bit value so widening to XLEN sign-extends U-type too.
  always_comb begin
    imm32 = '0;
    case (typ)
      T_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
      T_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      T_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U:     imm32 = {inst[31:12], 12'b0};
      T_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.pc        = pc;
    dec.op_class  = cls;
    dec.inst_type = typ;
    dec.rd        = inst[11:7];
    dec.rs1       = inst[19:15];
    dec.rs2       = inst[24:20];
    dec.imm       = XLEN'(imm32);
    dec.shamt     = inst[20 +: SHAMT_WIDTH];
    dec.illegal   = (cls == C_INV);
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_TWO;
          else if (out_fire && !in_fire) state_d = ST_EMPTY;
        end
        ST_TWO:   if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      // A transfer completed in a flush cycle still counts.
      if (out_fire && !head_q.illegal && (cnt_q != {CNT_WIDTH{1'b1}}))
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (!flush) begin
        case (state_q)
          ST_EMPTY: if (in_fire) head_q <= dec;
          ST_ONE: begin
            if (in_fire && !out_fire)     skid_q <= dec;
            else if (in_fire && out_fire) head_q <= dec;
          end
          ST_TWO:   if (out_fire) head_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = head_q.pc;
  assign op_class   = head_q.op_class;
  assign inst_type  = head_q.inst_type;
  assign rd         = head_q.rd;
  assign rs1        = head_q.rs1;
  assign rs2        = head_q.rs2;
  assign imm        = head_q.imm;
  assign shamt      = head_q.shamt;
  assign illegal    = head_q.illegal;
  assign decode_cnt = cnt_q;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Bench: an RV32 (16-bit counter) and an RV64 (2-bit counter) instance share one stimulus
// stream; a queue-based reference model predicts the buffer contents and decoded fields.
module tb_idu_decode_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;

  logic a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [3:0] a_op_class;
  logic [2:0] a_inst_type;
  logic [4:0] a_rd, a_rs1, a_rs2, a_shamt;
  logic [15:0] a_cnt;

  logic b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [3:0] b_op_class;
  logic [2:0] b_inst_type;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [5:0] b_shamt;
  logic [1:0] b_cnt;

  idu_decode_stage #(.XLEN(32), .SHAMT_WIDTH(5), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .inst(inst),
    .pc(pc[31:0]), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .op_class(a_op_class), .inst_type(a_inst_type), .rd(a_rd),
    .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm), .shamt(a_shamt), .illegal(a_illegal),
    .decode_cnt(a_cnt));

  idu_decode_stage #(.XLEN(64), .SHAMT_WIDTH(6), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .inst(inst),
    .pc(pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .op_class(b_op_class), .inst_type(b_inst_type), .rd(b_rd),
    .rs1(b_rs1), .rs2(b_rs2), .imm(b_imm), .shamt(b_shamt), .illegal(b_illegal),
    .decode_cnt(b_cnt));

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  cls;
    logic [2:0]  typ;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic [5:0]  shamt;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;
  int unsigned cnt_a = 0, cnt_b = 0;
  bit mon_en = 0, post_rst = 0;
  logic [31:0] dirs [7] = '{32'hFFF00093, 32'h123452B7, 32'hFE000EE3, 32'h800000EF,
                            32'h0010009B, 32'h80000537, 32'h0000003B};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference decode: class from an opcode table, immediate assembled with 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p, input bit is64);
    exp_t e;
    longint s;
    longint v;
    s = longint'($signed(i));
    e.pc = is64 ? p : {32'b0, p[31:0]};
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.shamt = is64 ? i[25:20] : {1'b0, i[24:20]};
    e.cls = 4'd0; e.typ = 3'd0;
    case (i[6:0])
      7'h37: begin e.cls = 4'd1;  e.typ = 3'd5; end
      7'h17: begin e.cls = 4'd2;  e.typ = 3'd5; end
      7'h6F: begin e.cls = 4'd3;  e.typ = 3'd6; end
      7'h67: begin e.cls = 4'd4;  e.typ = 3'd2; end
      7'h63: begin e.cls = 4'd5;  e.typ = 3'd4; end
      7'h03: begin e.cls = 4'd6;  e.typ = 3'd2; end
      7'h23: begin e.cls = 4'd7;  e.typ = 3'd3; end
      7'h13: begin e.cls = 4'd8;  e.typ = 3'd2; end
      7'h33: begin e.cls = 4'd9;  e.typ = 3'd1; end
      7'h73: begin e.cls = 4'd10; e.typ = 3'd2; end
      7'h1B: if (is64) begin e.cls = 4'd11; e.typ = 3'd2; end
      7'h3B: if (is64) begin e.cls = 4'd12; e.typ = 3'd1; end
      default: ;
    endcase
    e.ill = (e.cls == 4'd0);
    case (e.typ)
      3'd2: v = s >>> 20;
      3'd3: v = ((s >>> 25) << 5) | longint'(i[11:7]);
      3'd4: v = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
                | (longint'(i[11:8]) << 1);
      3'd5: v = s & ~longint'(64'hFFF);
      3'd6: v = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
                | (longint'(i[30:21]) << 1);
      default: v = 0;
    endcase
    e.imm = is64 ? 64'(v) : {32'b0, 32'(v)};
    return e;
  endfunction

  // Monitor: checks handshake/counter every cycle, pops the scoreboard on each DUT transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
      chk("b_in_ready", 64'(b_in_ready), 64'(qb.size() < 2));
      chk("a_decode_cnt", 64'(a_cnt), 64'(cnt_a));
      chk("b_decode_cnt", 64'(b_cnt), 64'(cnt_b));
      if (post_rst) begin
        chk("a_rst_pc_imm", {a_out_pc, a_imm}, 64'd0);
        chk("a_rst_fields", 64'({a_op_class, a_inst_type, a_rd, a_rs1, a_rs2, a_shamt, a_illegal}), 64'd0);
        chk("b_rst_pc", b_out_pc, 64'd0);
        chk("b_rst_imm", b_imm, 64'd0);
        chk("b_rst_fields", 64'({b_op_class, b_inst_type, b_rd, b_rs1, b_rs2, b_shamt, b_illegal}), 64'd0);
        post_rst = 0;
      end
      if (a_out_valid && qa.size() > 0) begin
        chk("a_pc", 64'(a_out_pc), qa[0].pc);
        chk("a_op_class", 64'(a_op_class), 64'(qa[0].cls));
        chk("a_inst_type", 64'(a_inst_type), 64'(qa[0].typ));
        chk("a_regs", 64'({a_rd, a_rs1, a_rs2}), 64'({qa[0].rd, qa[0].rs1, qa[0].rs2}));
        chk("a_imm", 64'(a_imm), qa[0].imm);
        chk("a_shamt", 64'(a_shamt), 64'(qa[0].shamt));
        chk("a_illegal", 64'(a_illegal), 64'(qa[0].ill));
        if (out_ready) begin
          if (!qa[0].ill && cnt_a < 65535) cnt_a++;
          void'(qa.pop_front());
        end
      end
      if (b_out_valid && qb.size() > 0) begin
        chk("b_pc", b_out_pc, qb[0].pc);
        chk("b_op_class", 64'(b_op_class), 64'(qb[0].cls));
        chk("b_inst_type", 64'(b_inst_type), 64'(qb[0].typ));
        chk("b_regs", 64'({b_rd, b_rs1, b_rs2}), 64'({qb[0].rd, qb[0].rs1, qb[0].rs2}));
        chk("b_imm", b_imm, qb[0].imm);
        chk("b_shamt", 64'(b_shamt), 64'(qb[0].shamt));
        chk("b_illegal", 64'(b_illegal), 64'(qb[0].ill));
        if (out_ready) begin
          if (!qb[0].ill && cnt_b < 3) cnt_b++;
          void'(qb.pop_front());
        end
      end
      if (flush || rst) begin
        qa.delete();
        qb.delete();
      end
      if (rst) begin
        cnt_a = 0;
        cnt_b = 0;
        post_rst = 1;
      end
    end
  end

  // One clock of stimulus; the entry is pushed after the monitor has retired this edge's output.
  task automatic cyc(input bit v, input logic [31:0] ins, input bit fl, input bit ordy,
                     input bit r, output bit acc);
    exp_t ea, eb;
    logic [63:0] p;
    @(posedge clk);
    #1;
    p = {$urandom, $urandom};
    rst = r; in_valid = v; inst = ins; pc = p; flush = fl; out_ready = ordy;
    acc = v && (qa.size() < 2);
    ea = model(ins, p, 1'b0);
    eb = model(ins, p, 1'b1);
    @(negedge clk);
    #1;
    if (acc && !fl && !r) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    logic [6:0] op;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    case ($urandom_range(0, 11))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67;
      4: op = 7'h63; 5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13;
      8: op = 7'h33; 9: op = 7'h73; 10: op = 7'h1B; default: op = 7'h3B;
    endcase
    if (sel < 6) r[6:0] = op;
    else if (sel == 9) r = dirs[$urandom_range(0, 6)];
    return r;
  endfunction

  bit acc;
  logic [31:0] x3;

  initial begin
    cyc(0, 0, 0, 0, 1, acc);
    mon_en = 1;
    cyc(0, 0, 0, 0, 1, acc);
    for (int i = 0; i < 7; i++) cyc(1, dirs[i], 0, 1, 0, acc);
    repeat (2) cyc(0, 0, 0, 1, 0, acc);

    // Backpressure: three pushes against a stalled sink, then drain.
    cyc(1, dirs[0], 0, 0, 0, acc);
    cyc(1, dirs[1], 0, 0, 0, acc);
    x3 = dirs[2];
    cyc(1, x3, 0, 0, 0, acc);
    acc = 0;
    for (int k = 0; k < 6 && !acc; k++) cyc(1, x3, 0, 1, 0, acc);
    if (!acc) chk("bp_third_accept", 0, 1);
    repeat (3) cyc(0, 0, 0, 1, 0, acc);

    // Flush from full, without and then with a simultaneous transfer.
    cyc(1, dirs[3], 0, 0, 0, acc);
    cyc(1, dirs[4], 0, 0, 0, acc);
    cyc(1, dirs[5], 1, 0, 0, acc);
    repeat (2) cyc(0, 0, 0, 1, 0, acc);
    cyc(1, dirs[0], 0, 0, 0, acc);
    cyc(1, dirs[1], 0, 0, 0, acc);
    cyc(1, dirs[2], 1, 1, 0, acc);
    repeat (2) cyc(0, 0, 0, 1, 0, acc);

    // Counter saturation after reset, then reset with entries in flight.
    cyc(0, 0, 0, 0, 1, acc);
    repeat (5) cyc(1, dirs[0], 0, 1, 0, acc);
    repeat (2) cyc(0, 0, 0, 1, 0, acc);
    cyc(1, dirs[1], 0, 0, 0, acc);
    cyc(1, dirs[2], 0, 0, 0, acc);
    cyc(1, dirs[3], 0, 0, 1, acc);
    cyc(0, 0, 0, 1, 0, acc);

    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 9) < 7, rnd_inst(), $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0, acc);
    repeat (4) cyc(0, 0, 0, 1, 0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
